rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Shares the single register-file write port (`we`/`waddr`/`wdata` of `idecode`) between the in-order pipeline writeback and a long-latency unit (mul/div or load). It also tracks registers with outstanding long-latency results in a scoreboard and stalls issue on RAW/WAW hazards against them. It sits between the writeback stage, the long-latency unit and `idecode`, and drives the issue-stall line to the decode stage.

## Interface
- `STARVE_MAX`, 4: consecutive lost conflicts after which requester B takes priority (≥1).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `a_valid` in 1: pipeline writeback request.
- `a_ready` out 1: A handshake accepted this cycle.
- `a_waddr` in 5: A destination register.
- `a_wdata` in 32: A write data.
- `b_valid` in 1: long-latency unit result request.
- `b_ready` out 1: B handshake accepted this cycle.
- `b_waddr` in 5: B destination register.
- `b_wdata` in 32: B write data.
- `iss_valid` in 1: instruction at issue.
- `iss_rs1` in 5, `iss_rs2` in 5, `iss_rd` in 5: issue operand and destination registers.
- `iss_long` in 1: issuing instruction completes through B.
- `iss_stall` out 1: hold issue.
- `rf_we` out 1: to `idecode.we`.
- `rf_waddr` out 5: to `idecode.waddr`.
- `rf_wdata` out 32: to `idecode.wdata`.

## Operation
- A grant: `a_valid && a_ready`. B grant: `b_valid && b_ready`. At most one grant per cycle.
- `b_prio = (starve_cnt == STARVE_MAX)`. `a_ready = !b_valid || !b_prio`. `b_ready = !a_valid || b_prio`.
- With both requesters valid, A wins unless `b_prio`.
- `starve_cnt` (width `$clog2(STARVE_MAX+1)`):
  - Increments when `b_valid && !b_ready`, saturating at `STARVE_MAX`.
  - Clears to 0 on a B grant.
  - Holds otherwise.
- Output stage: on any grant, load `rf_waddr`/`rf_wdata` from the winner. `rf_we <= (waddr != 0)`, so x0 writes handshake normally but never assert `rf_we`. No grant: `rf_we <= 0` and address/data hold.
- An `rf_src` flop records whether the output stage holds a B write.
- Scoreboard: 32-bit `pending`; bit 0 is hardwired 0.
  - Set `pending[iss_rd]` when `iss_valid && !iss_stall && iss_long && iss_rd != 0`.
  - Clear `pending[rf_waddr]` at the edge ending a cycle with `rf_we && rf_src == B`. This is the same edge the register file commits, so readers see the bit drop and the data arrive together.
  - Set and clear of the same register at the same edge: set wins.
- `iss_stall = iss_valid && (pending[iss_rs1] || pending[iss_rs2] || pending[iss_rd])`. The zero register never matches.
- A writes to a pending register are not blocked here; WAW is prevented by the issue stall on `iss_rd`.

## Timing
- Reset values: `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `rf_src=A`, `pending=0`, `starve_cnt=0`. `a_ready`/`b_ready`/`iss_stall` follow from these combinationally.
- Reset mid-operation: the in-flight output write is dropped, all pending bits are lost and the counter is zeroed.
- `a_ready`, `b_ready`, `iss_stall` are combinational from inputs and state; no ready-to-valid dependency.
- Latency: grant in cycle t gives `rf_we` in cycle t+1, and the data is readable from `idecode` in cycle t+2. Pending clear is also visible in t+2.
- Single-requester throughput: one write per cycle.
- Under continuous A and B contention: B is granted at least once every `STARVE_MAX+1` cycles.

## Configuration
- `RF_ARB_STARVE_EN` defined: `starve_cnt` and `b_prio` are implemented as above.
- `RF_ARB_STARVE_EN` undefined: no counter, `b_prio` is constant 0 and A has strict priority. B may starve indefinitely; the pipeline must drain A to let B through.

## Structure
- Package `rf_arb_pkg`:
  - `XLEN=32`, `REG_AW=5`, `NREGS=32`.
  - Enum `wb_src_e {SRC_A, SRC_B}` for `rf_src`.
- Sub-module `rf_scoreboard`:
  - Owns the `pending` vector, set/clear logic and `iss_stall`.
  - Takes the set port (`iss_*`) and the clear port (`clr_en`, `clr_addr`).
- Arbitration, the counter and the output stage stay in the top level.

## Test plan
- A only, `a_waddr=5`, `a_wdata=0xDEADBEEF`: `a_ready=1`; the next cycle `rf_we=1`, `rf_waddr=5`, `rf_wdata=0xDEADBEEF`. Write to x0: handshake, `rf_we=0`.
- A and B both valid continuously, `STARVE_MAX=4`: grants A,A,A,A,B repeating, `b_ready` high every 5th cycle. With the macro undefined: B is never granted.
- Issue with `iss_long=1`, `iss_rd=7`, then a consumer with `iss_rs1=7`: `iss_stall=1` until the cycle after B's write to x7 has `rf_we=1`, then 0.
- Issue `iss_long=1`, `iss_rd=7` in the same cycle that the output stage holds the B write to x7: `pending[7]` remains 1.
- Assert `rst` while `rf_we=1` and `pending[3]=1`: all outputs are 0 immediately (asynchronous), and `iss_stall=0` for `iss_rs1=3`.
- `iss_rd=0` with `iss_long=1`: no pending bit is set and no stall occurs on later x0 operands.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared widths and the writeback-source enum for the register-file write-port arbiter.
package rf_arb_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int NREGS  = 32;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } wb_src_e;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-result scoreboard for long-latency destinations; raises the issue stall on RAW/WAW hazards.
module rf_scoreboard
   import rf_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rs1,
   input  logic [REG_AW-1:0] iss_rs2,
   input  logic [REG_AW-1:0] iss_rd,
   input  logic              iss_long,
   input  logic              clr_en,
   input  logic [REG_AW-1:0] clr_addr,
   output logic              iss_stall
);

   logic [NREGS-1:0] pending_q;
   logic [NREGS-1:0] pending_d;
   logic             set_en;

   assign set_en = iss_valid && !iss_stall && iss_long && (iss_rd != '0);

   // x0 never holds a pending result, so it can never match an operand.
   assign pending_d[0] = 1'b0;

   generate
      for (genvar gi = 1; gi < NREGS; gi++) begin : g_bit
         // Set has priority over a same-edge clear of the same register.
         assign pending_d[gi] = (set_en && (iss_rd == REG_AW'(gi)))
                             || (pending_q[gi] && !(clr_en && (clr_addr == REG_AW'(gi))));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign iss_stall = iss_valid && (pending_q[iss_rs1] || pending_q[iss_rs2] || pending_q[iss_rd]);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback (A) and a long-latency unit (B).
// Define RF_ARB_STARVE_EN to give B priority after STARVE_MAX consecutive lost conflicts; otherwise A has strict priority.
module rf_wb_arbiter
   import rf_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [REG_AW-1:0] a_waddr,
   input  logic [XLEN-1:0]   a_wdata,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [REG_AW-1:0] b_waddr,
   input  logic [XLEN-1:0]   b_wdata,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rs1,
   input  logic [REG_AW-1:0] iss_rs2,
   input  logic [REG_AW-1:0] iss_rd,
   input  logic              iss_long,
   output logic              iss_stall,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [XLEN-1:0]   rf_wdata
);

   generate
      if (STARVE_MAX < 1) begin : g_bad_param
         $error("rf_wb_arbiter: STARVE_MAX must be at least 1");
      end
   endgenerate

   logic              b_prio;
   logic              a_gnt;
   logic              b_gnt;
   logic              rf_we_q,    rf_we_d;
   logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
   wb_src_e           rf_src_q,   rf_src_d;

`ifdef RF_ARB_STARVE_EN
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] starve_q, starve_d;

   always_comb begin
      starve_d = starve_q;
      if (b_gnt) begin
         starve_d = '0;
      end else if (b_valid && !b_ready && (starve_q != CNT_W'(STARVE_MAX))) begin
         starve_d = starve_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

   assign b_prio = (starve_q == CNT_W'(STARVE_MAX));
`else
   assign b_prio = 1'b0;
`endif

   // The two readies are mutually exclusive whenever both requesters are valid.
   assign a_ready = !b_valid || !b_prio;
   assign b_ready = !a_valid || b_prio;
   assign a_gnt   = a_valid && a_ready;
   assign b_gnt   = b_valid && b_ready;

   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      rf_src_d   = rf_src_q;
      if (b_gnt) begin
         rf_we_d    = (b_waddr != '0);
         rf_waddr_d = b_waddr;
         rf_wdata_d = b_wdata;
         rf_src_d   = SRC_B;
      end else if (a_gnt) begin
         rf_we_d    = (a_waddr != '0);
         rf_waddr_d = a_waddr;
         rf_wdata_d = a_wdata;
         rf_src_d   = SRC_A;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         rf_src_q   <= SRC_A;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         rf_src_q   <= rf_src_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

   // Clearing on the register-file commit edge makes the bit drop and the data land together.
   rf_scoreboard u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .iss_valid (iss_valid),
      .iss_rs1   (iss_rs1),
      .iss_rs2   (iss_rs2),
      .iss_rd    (iss_rd),
      .iss_long  (iss_long),
      .clr_en    (rf_we_q && (rf_src_q == SRC_B)),
      .clr_addr  (rf_waddr_q),
      .iss_stall (iss_stall)
   );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed, table-driven bench for rf_wb_arbiter plus hand sequences for contention, set-wins and async reset.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic        a_ready, b_ready;
   logic [4:0]  a_waddr = '0, b_waddr = '0;
   logic [31:0] a_wdata = '0, b_wdata = '0;
   logic        iss_valid = 1'b0, iss_long = 1'b0;
   logic [4:0]  iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
   logic        iss_stall;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   rf_wb_arbiter #(.STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_waddr(a_waddr), .a_wdata(a_wdata),
      .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
      .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
      .iss_long(iss_long), .iss_stall(iss_stall),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   typedef struct {
      logic        av;  logic [4:0] aa; logic [31:0] ad;
      logic        bv;  logic [4:0] ba; logic [31:0] bd;
      logic        iv;  logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd; logic il;
      logic        e_ar; logic e_br; logic e_st; logic e_we;
      logic [4:0]  e_wa; logic [31:0] e_wd;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      a_valid = v.av; a_waddr = v.aa; a_wdata = v.ad;
      b_valid = v.bv; b_waddr = v.ba; b_wdata = v.bd;
      iss_valid = v.iv; iss_rs1 = v.rs1; iss_rs2 = v.rs2; iss_rd = v.rd; iss_long = v.il;
   endtask

   task automatic idle();
      a_valid = 0; b_valid = 0; iss_valid = 0; iss_long = 0;
      iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
   endtask

   initial begin
      // av aa ad            bv ba bd            iv rs1 rs2 rd il   ar br st we wa  wd
      vecs[0]  = '{0,0,32'h0,        0,0,32'h0,        0,0,0,0,0,   1,1,0,0,0,32'h0};
      vecs[1]  = '{1,5,32'hDEADBEEF, 0,0,32'h0,        0,0,0,0,0,   1,0,0,0,0,32'h0};
      vecs[2]  = '{1,0,32'h12345678, 0,0,32'h0,        0,0,0,0,0,   1,0,0,1,5,32'hDEADBEEF};
      vecs[3]  = '{0,0,32'h0,        0,0,32'h0,        0,0,0,0,0,   1,1,0,0,0,32'h12345678};
      vecs[4]  = '{0,0,32'h0,        0,0,32'h0,        1,0,0,7,1,   1,1,0,0,0,32'h12345678};
      vecs[5]  = '{0,0,32'h0,        0,0,32'h0,        1,7,0,8,0,   1,1,1,0,0,32'h12345678};
      vecs[6]  = '{0,0,32'h0,        1,7,32'hCAFEF00D, 1,7,0,8,0,   1,1,1,0,0,32'h12345678};
      vecs[7]  = '{0,0,32'h0,        0,0,32'h0,        1,7,0,8,0,   1,1,1,1,7,32'hCAFEF00D};
      vecs[8]  = '{0,0,32'h0,        0,0,32'h0,        1,7,0,8,0,   1,1,0,0,7,32'hCAFEF00D};
      vecs[9]  = '{1,1,32'h11,       1,2,32'h22,       0,0,0,0,0,   1,0,0,0,7,32'hCAFEF00D};
      vecs[10] = '{1,1,32'h11,       1,2,32'h22,       0,0,0,0,0,   1,0,0,1,1,32'h11};
      vecs[11] = '{0,0,32'h0,        1,2,32'h22,       0,0,0,0,0,   1,1,0,1,1,32'h11};
      vecs[12] = '{0,0,32'h0,        0,0,32'h0,        0,0,0,0,0,   1,1,0,1,2,32'h22};
      vecs[13] = '{0,0,32'h0,        0,0,32'h0,        1,0,0,0,1,   1,1,0,0,2,32'h22};
      vecs[14] = '{0,0,32'h0,        0,0,32'h0,        1,0,0,0,0,   1,1,0,0,2,32'h22};
      vecs[15] = '{0,0,32'h0,        0,0,32'h0,        1,0,7,0,0,   1,1,0,0,2,32'h22};

      repeat (2) @(posedge clk);
      #1 rst = 0;

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i]);
         #3;
         check($sformatf("v%0d a_ready", i),   32'(a_ready),   32'(vecs[i].e_ar));
         check($sformatf("v%0d b_ready", i),   32'(b_ready),   32'(vecs[i].e_br));
         check($sformatf("v%0d iss_stall", i), 32'(iss_stall), 32'(vecs[i].e_st));
         check($sformatf("v%0d rf_we", i),     32'(rf_we),     32'(vecs[i].e_we));
         check($sformatf("v%0d rf_waddr", i),  32'(rf_waddr),  32'(vecs[i].e_wa));
         check($sformatf("v%0d rf_wdata", i),  rf_wdata,       vecs[i].e_wd);
         $display("vec %0d: a_rdy=%0b b_rdy=%0b stall=%0b we=%0b waddr=%0d wdata=%h",
                  i, a_ready, b_ready, iss_stall, rf_we, rf_waddr, rf_wdata);
         step();
      end

      // Set-wins: new long issue to x7 while the output stage holds a B write to x7.
      idle();
      b_valid = 1; b_waddr = 7; b_wdata = 32'h77;
      step();
      b_valid = 0;
      iss_valid = 1; iss_rd = 7; iss_long = 1;
      #3;
      check("setwins rf_we", 32'(rf_we), 32'd1);
      check("setwins issue stall", 32'(iss_stall), 32'd0);
      step();
      iss_long = 0; iss_rd = 9; iss_rs1 = 7;
      #3;
      check("setwins pending7 stall", 32'(iss_stall), 32'd1);
      $display("setwins: stall on x7 after same-edge set/clear = %0b", iss_stall);
      step();
      idle();
      b_valid = 1; b_waddr = 7; b_wdata = 32'h78;
      step();
      b_valid = 0;
      step();
      iss_valid = 1; iss_rs1 = 7;
      #3;
      check("setwins drained stall", 32'(iss_stall), 32'd0);
      step();
      idle();

      // Continuous contention; the starve counter is zero after the last B grant.
      begin
         logic [4:0] exp_wa;
         logic       exp_br;
         a_valid = 1; a_waddr = 10; a_wdata = 32'hA0;
         b_valid = 1; b_waddr = 11; b_wdata = 32'hB0;
         for (int k = 0; k < 15; k++) begin
`ifdef RF_ARB_STARVE_EN
            exp_br = ((k % 5) == 4);
`else
            exp_br = 1'b0;
`endif
            exp_wa = exp_br ? 5'd11 : 5'd10;
            #3;
            check($sformatf("cont%0d b_ready", k), 32'(b_ready), 32'(exp_br));
            check($sformatf("cont%0d a_ready", k), 32'(a_ready), 32'(!exp_br));
            step();
            check($sformatf("cont%0d rf_waddr", k), 32'(rf_waddr), 32'(exp_wa));
            $display("cont %0d: b_ready=%0b winner_waddr=%0d", k, b_ready, rf_waddr);
         end
         idle();
      end

      // Async reset while rf_we=1 and pending[3]=1.
      a_valid = 1; a_waddr = 4; a_wdata = 32'h44;
      iss_valid = 1; iss_rd = 3; iss_long = 1;
      step();
      idle();
      iss_valid = 1; iss_rs1 = 3;
      #1;
      check("prerst rf_we", 32'(rf_we), 32'd1);
      check("prerst stall", 32'(iss_stall), 32'd1);
      #1 rst = 1;
      #1;
      check("rst rf_we", 32'(rf_we), 32'd0);
      check("rst rf_waddr", 32'(rf_waddr), 32'd0);
      check("rst rf_wdata", rf_wdata, 32'd0);
      check("rst stall", 32'(iss_stall), 32'd0);
      $display("async reset: we=%0b waddr=%0d wdata=%h stall=%0b", rf_we, rf_waddr, rf_wdata, iss_stall);
      #1 rst = 0;
      step();
      #3;
      check("postrst stall", 32'(iss_stall), 32'd0);
      check("postrst rf_we", 32'(rf_we), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
